alu_result_stage: RTL

- Downstream stage of the ALU. Captures each 32-bit ALU result C together with its 5-bit op code into the result register.
- Computes zero and negative status flags at capture.
- Presents the result to the bus/writeback side through a valid/ready handshake.
- A 2-entry skid buffer lets the producer be stalled without losing a result. Outputs are fully registered, so there is no combinational path from out_ready to in_ready.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/result_flags.sv | 14 +
 rtl/alu_result_stage.sv | 125 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, op codes and the packed result-entry type.
// Used by the ALU and by every stage that carries its results.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 5;

    localparam logic [OP_W-1:0] OP_OR  = 5'd0;
    localparam logic [OP_W-1:0] OP_AND = 5'd1;
    localparam logic [OP_W-1:0] OP_ADD = 5'd2;
    localparam logic [OP_W-1:0] OP_NEG = 5'd3;

    typedef struct packed {
        logic [0:DATA_W-1] result;
        logic [OP_W-1:0]   op;
        logic              zero;
        logic              neg;
    } result_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_TWO
    } occ_t;

endpackage

// File: rtl/result_flags.sv
// Zero/negative status of a result word whose bit 0 is the sign bit.
// Purely combinational so branch logic can reuse it.
module result_flags #(
    parameter int W = 32
) (
    input  logic [0:W-1] word,
    output logic         zero,
    output logic         neg
);

    assign zero = (word == '0);
    assign neg  = word[0];

endmodule

// File: rtl/alu_result_stage.sv
// ALU result register with zero/neg flags, 2-entry skid buffer and delivered-result counter.
//
// state     | meaning
// OCC_EMPTY | no result held, in_ready=1
// OCC_ONE   | main entry valid, skid empty, in_ready=1
// OCC_TWO   | main and skid valid, in_ready=0
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int OP_W   = alu_pkg::OP_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:DATA_W-1] in_result,
    input  logic [OP_W-1:0]   in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:DATA_W-1] out_result,
    output logic [OP_W-1:0]   out_op,
    output logic              out_zero,
    output logic              out_neg,
    output logic [CNT_W-1:0]  res_count
);

    typedef struct packed {
        logic [0:DATA_W-1] result;
        logic [OP_W-1:0]   op;
        logic              zero;
        logic              neg;
    } entry_t;

    entry_t           m_q, m_d, s_q, s_d, in_ent;
    logic             m_vld_q, m_vld_d, s_vld_q, s_vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flag_zero, flag_neg;
    logic             accept, drain;
    occ_t             occ;

    result_flags #(.W(DATA_W)) u_flags (
        .word (in_result),
        .zero (flag_zero),
        .neg  (flag_neg)
    );

    assign in_ent = '{result: in_result, op: in_op, zero: flag_zero, neg: flag_neg};

    // in_ready comes straight from a flop, so out_ready never reaches it combinationally
    assign in_ready = ~s_vld_q;
    assign accept   = in_valid & in_ready;
    assign drain    = m_vld_q & out_ready;

    always_comb begin
        if (s_vld_q)      occ = OCC_TWO;
        else if (m_vld_q) occ = OCC_ONE;
        else              occ = OCC_EMPTY;
    end

    always_comb begin
        m_d     = m_q;
        s_d     = s_q;
        m_vld_d = m_vld_q;
        s_vld_d = s_vld_q;
        cnt_d   = cnt_q;
        if (flush) begin
            m_vld_d = 1'b0;
            s_vld_d = 1'b0;
        end else begin
            if (drain && cnt_q != '1) cnt_d = cnt_q + 1'b1;
            unique case (occ)
                OCC_EMPTY: begin
                    if (accept) begin
                        m_d     = in_ent;
                        m_vld_d = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (drain && accept) begin
                        m_d = in_ent;
                    end else if (drain) begin
                        m_vld_d = 1'b0;
                    end else if (accept) begin
                        s_d     = in_ent;
                        s_vld_d = 1'b1;
                    end
                end
                OCC_TWO: begin
                    if (drain) begin
                        m_d     = s_q;
                        s_vld_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_q     <= '0;
            s_q     <= '0;
            m_vld_q <= 1'b0;
            s_vld_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            m_q     <= m_d;
            s_q     <= s_d;
            m_vld_q <= m_vld_d;
            s_vld_q <= s_vld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid  = m_vld_q;
    assign out_result = m_q.result;
    assign out_op     = m_q.op;
    assign out_zero   = m_q.zero;
    assign out_neg    = m_q.neg;
    assign res_count  = cnt_q;

endmodule
